// File: rtl/game_move_sched.sv
// game_move_sched: tick generation, button/accel move arbitration and game-state sequencing for Ball
module game_move_sched #(
    parameter int CLK_HZ        = 100000000,
    parameter int BTN_RATE_HZ   = 90,
    parameter int FRAME_RATE_HZ = 60,
    parameter int HOLD_FRAMES   = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_req,
    input  logic [3:0] accel_req,
    input  logic       start,
    input  logic       gameover,
    output logic [3:0] movement,
    output logic       btn_tick,
    output logic       frame_tick,
    output logic [1:0] state,
    output logic       src_accel,
    output logic       restart
);
    localparam logic [31:0] BTOP = 32'(CLK_HZ / BTN_RATE_HZ - 1);
    localparam logic [31:0] FTOP = 32'(CLK_HZ / FRAME_RATE_HZ - 1);
    localparam logic [31:0] HOLD = 32'(HOLD_FRAMES);
    localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2;
    logic [31:0] btn_cnt, frame_cnt, hold_cnt;
    logic start_q, btn_active, start_rise;
    logic [3:0] raw, moves;
    always_comb begin
        btn_active = |btn_req;
        start_rise = start & ~start_q;
        raw = btn_active ? (btn_tick ? btn_req : 4'd0) : accel_req;
        // opposite directions on the same axis cancel each other; diagonals pass
        moves = {raw[3:2] & {2{~&raw[3:2]}}, raw[1:0] & {2{~&raw[1:0]}}};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_cnt    <= '0;
            frame_cnt  <= '0;
            hold_cnt   <= '0;
            start_q    <= 1'b0;
            btn_tick   <= 1'b0;
            frame_tick <= 1'b0;
            movement   <= 4'd0;
            state      <= IDLE;
            src_accel  <= 1'b0;
            restart    <= 1'b0;
        end else begin
            btn_cnt    <= (btn_cnt == BTOP) ? '0 : btn_cnt + 32'd1;
            btn_tick   <= btn_cnt == BTOP;
            frame_cnt  <= (frame_cnt == FTOP) ? '0 : frame_cnt + 32'd1;
            frame_tick <= frame_cnt == FTOP;
            start_q    <= start;
            restart    <= 1'b0;
            movement   <= (state == PLAY && !gameover) ? moves : 4'd0;
            if (state == PLAY)
                src_accel <= ~btn_active;
            case (state)
                IDLE: if (start_rise && !gameover) state <= PLAY;
                PLAY: if (gameover) begin
                    state    <= OVER;
                    hold_cnt <= '0;
                end
                OVER: if (frame_tick) begin
                    if (hold_cnt + 32'd1 >= HOLD) begin
                        state    <= IDLE;
                        restart  <= 1'b1;
                        hold_cnt <= '0;
                    end else
                        hold_cnt <= hold_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
